// File: rtl/pipe_ctrl.sv
// Y86-64 pipeline control: per-stage stall/bubble generation, CC write gating,
// run/halt state machine and architectural performance counters.
module pipe_ctrl #(
    parameter int CNT_W = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       D_icode,
    input  logic [3:0]       E_icode,
    input  logic [3:0]       M_icode,
    input  logic [3:0]       d_srcA,
    input  logic [3:0]       d_srcB,
    input  logic [3:0]       E_dstM,
    input  logic             e_Cnd,
    input  logic [2:0]       m_stat,
    input  logic [2:0]       W_stat,
    input  logic [3:0]       W_icode,
    output logic             F_stall,
    output logic             D_stall,
    output logic             W_stall,
    output logic             D_bubble,
    output logic             E_bubble,
    output logic             M_bubble,
    output logic             set_cc,
    output logic             halted,
    output logic [2:0]       final_stat,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] retire_cnt,
    output logic [CNT_W-1:0] bubble_cnt
);

    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_POPQ   = 4'hB;
    localparam logic [3:0] R_NONE   = 4'hF;

    localparam logic [2:0] S_AOK = 3'd1;
    localparam logic [2:0] S_HLT = 3'd2;
    localparam logic [2:0] S_ADR = 3'd3;
    localparam logic [2:0] S_INS = 3'd4;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_t;

    function automatic logic is_exc(input logic [2:0] s);
        return (s == S_HLT) || (s == S_ADR) || (s == S_INS);
    endfunction

    state_t           state_q;
    logic             halted_q;
    logic [2:0]       final_stat_q;
    logic [CNT_W-1:0] cycle_q, cycle_d;
    logic [CNT_W-1:0] retire_q, retire_d;
    logic [CNT_W-1:0] bubble_q, bubble_d;

    logic loaduse, retpend, mispred, m_exc, w_exc;
    logic run_F_stall, run_D_stall, run_W_stall;
    logic run_D_bubble, run_E_bubble, run_M_bubble, run_set_cc;
    logic frozen;
    logic [1:0] bub_inc;

    always_comb begin
        loaduse = ((E_icode == I_MRMOVQ) || (E_icode == I_POPQ)) &&
                  (E_dstM != R_NONE) &&
                  ((E_dstM == d_srcA) || (E_dstM == d_srcB));
        retpend = (D_icode == I_RET) || (E_icode == I_RET) || (M_icode == I_RET);
        mispred = (E_icode == I_JXX) && !e_Cnd;
        m_exc   = is_exc(m_stat);
        w_exc   = is_exc(W_stat);

        run_F_stall  = loaduse | retpend;
        run_D_stall  = loaduse;
        // Load/use wins over the RET bubble so D is never both held and flushed.
        run_D_bubble = mispred | (retpend & ~loaduse);
        run_E_bubble = mispred | loaduse;
        run_M_bubble = m_exc | w_exc;
        run_W_stall  = w_exc;
        run_set_cc   = (E_icode == I_OPQ) & ~m_exc & ~w_exc;
    end

    // The frozen output set applies only once reset is released.
    assign frozen = (state_q == ST_HALTED) && rst_n;

    always_comb begin
        if (frozen) begin
            F_stall  = 1'b1;
            D_stall  = 1'b1;
            W_stall  = 1'b1;
            D_bubble = 1'b0;
            E_bubble = 1'b0;
            M_bubble = 1'b0;
            set_cc   = 1'b0;
        end else begin
            F_stall  = run_F_stall;
            D_stall  = run_D_stall;
            W_stall  = run_W_stall;
            D_bubble = run_D_bubble;
            E_bubble = run_E_bubble;
            M_bubble = run_M_bubble;
            set_cc   = run_set_cc;
        end
    end

    always_comb begin
        bub_inc  = {1'b0, run_D_bubble} + {1'b0, run_E_bubble} + {1'b0, run_M_bubble};
        cycle_d  = cycle_q + CNT_W'(1);
        retire_d = ((W_stat == S_AOK) && (W_icode != I_NOP)) ? retire_q + CNT_W'(1) : retire_q;
        bubble_d = bubble_q + CNT_W'(bub_inc);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_RUN;
            halted_q     <= 1'b0;
            final_stat_q <= S_AOK;
            cycle_q      <= '0;
            retire_q     <= '0;
            bubble_q     <= '0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    // Counters still advance on the edge that enters HALTED.
                    cycle_q  <= cycle_d;
                    retire_q <= retire_d;
                    bubble_q <= bubble_d;
                    if (w_exc) begin
                        state_q      <= ST_HALTED;
                        halted_q     <= 1'b1;
                        final_stat_q <= W_stat;
                    end
                end
                ST_HALTED: begin
                    state_q <= ST_HALTED;
                end
                default: begin
                    state_q <= ST_RUN;
                end
            endcase
        end
    end

    assign halted     = halted_q;
    assign final_stat = final_stat_q;
    assign cycle_cnt  = cycle_q;
    assign retire_cnt = retire_q;
    assign bubble_cnt = bubble_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: hand-built hazard vectors, directed multi-cycle
// sequences and randomized traffic checked against a behavioural model.
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  D_icode, E_icode, M_icode, d_srcA, d_srcB, E_dstM, W_icode;
    logic        e_Cnd;
    logic [2:0]  m_stat, W_stat;
    logic        F_stall, D_stall, W_stall, D_bubble, E_bubble, M_bubble, set_cc, halted;
    logic [2:0]  final_stat;
    logic [63:0] cycle_cnt, retire_cnt, bubble_cnt;

    pipe_ctrl #(.CNT_W(64)) dut (
        .clk(clk), .rst_n(rst_n),
        .D_icode(D_icode), .E_icode(E_icode), .M_icode(M_icode),
        .d_srcA(d_srcA), .d_srcB(d_srcB), .E_dstM(E_dstM),
        .e_Cnd(e_Cnd), .m_stat(m_stat), .W_stat(W_stat), .W_icode(W_icode),
        .F_stall(F_stall), .D_stall(D_stall), .W_stall(W_stall),
        .D_bubble(D_bubble), .E_bubble(E_bubble), .M_bubble(M_bubble),
        .set_cc(set_cc), .halted(halted), .final_stat(final_stat),
        .cycle_cnt(cycle_cnt), .retire_cnt(retire_cnt), .bubble_cnt(bubble_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    logic        m_halted;
    logic [2:0]  m_final;
    logic [63:0] m_cyc, m_ret, m_bub;

    typedef struct {
        logic [3:0] d, e, m, srcA, srcB, dstM;
        logic       cnd;
        logic [2:0] ms, ws;
        logic [6:0] exp;  // {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc}
    } vec_t;

    vec_t tbl[17];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    function automatic logic exc(input logic [2:0] s);
        return s inside {3'd2, 3'd3, 3'd4};
    endfunction

    // Expected control outputs from the hazard rules.
    function automatic logic [6:0] model_comb();
        logic lu, rp, mp, fr;
        lu = (E_icode inside {4'h5, 4'hB}) && (E_dstM != 4'hF) &&
             ((E_dstM == d_srcA) || (E_dstM == d_srcB));
        rp = (D_icode == 4'h9) || (E_icode == 4'h9) || (M_icode == 4'h9);
        mp = (E_icode == 4'h7) && !e_Cnd;
        fr = m_halted && rst_n;
        if (fr) return 7'b1100010;
        return {lu | rp, lu, mp | (rp & !lu), mp | lu,
                exc(m_stat) | exc(W_stat), exc(W_stat),
                (E_icode == 4'h6) && !exc(m_stat) && !exc(W_stat)};
    endfunction

    function automatic logic [6:0] dut_comb();
        return {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc};
    endfunction

    task automatic chk_comb(input string nm);
        chk(nm, 64'(dut_comb()), 64'(model_comb()));
    endtask

    task automatic chk_regs(input string nm);
        chk({nm, ".halted"}, 64'(halted), 64'(m_halted));
        chk({nm, ".final"}, 64'(final_stat), 64'(m_final));
        chk({nm, ".cycle"}, cycle_cnt, m_cyc);
        chk({nm, ".retire"}, retire_cnt, m_ret);
        chk({nm, ".bubble"}, bubble_cnt, m_bub);
    endtask

    // Advance one clock edge, updating the model with the inputs present at that edge.
    task automatic tick();
        logic [6:0] e;
        e = model_comb();
        if (!rst_n) begin
            m_halted = 1'b0; m_final = 3'd1; m_cyc = 0; m_ret = 0; m_bub = 0;
        end else if (!m_halted) begin
            m_cyc = m_cyc + 1;
            if (W_stat == 3'd1 && W_icode != 4'h1) m_ret = m_ret + 1;
            m_bub = m_bub + 64'(e[4]) + 64'(e[3]) + 64'(e[2]);
            if (exc(W_stat)) begin
                m_halted = 1'b1;
                m_final  = W_stat;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        D_icode = 4'h1; E_icode = 4'h1; M_icode = 4'h1; W_icode = 4'h1;
        d_srcA = 4'hF; d_srcB = 4'hF; E_dstM = 4'hF; e_Cnd = 1'b0;
        m_stat = 3'd1; W_stat = 3'd1;
    endtask

    task automatic apply(input vec_t v);
        D_icode = v.d; E_icode = v.e; M_icode = v.m;
        d_srcA = v.srcA; d_srcB = v.srcB; E_dstM = v.dstM;
        e_Cnd = v.cnd; m_stat = v.ms; W_stat = v.ws;
    endtask

    logic [63:0] base_bub, base_cyc, base_ret;

    initial begin
        //                d     e     m     srcA  srcB  dstM  cnd   ms    ws    F D Db Eb Mb Ws cc
        tbl[0]  = '{4'h1, 4'h1, 4'h1, 4'hF, 4'hF, 4'hF, 1'b0, 3'd1, 3'd1, 7'b0000000};
        tbl[1]  = '{4'h1, 4'h5, 4'h1, 4'hF, 4'h3, 4'h3, 1'b0, 3'd1, 3'd1, 7'b1101000};
        tbl[2]  = '{4'h1, 4'h5, 4'h1, 4'hF, 4'hF, 4'hF, 1'b0, 3'd1, 3'd1, 7'b0000000};
        tbl[3]  = '{4'h1, 4'hB, 4'h1, 4'h4, 4'hF, 4'h4, 1'b0, 3'd1, 3'd1, 7'b1101000};
        tbl[4]  = '{4'h9, 4'h1, 4'h1, 4'hF, 4'hF, 4'hF, 1'b0, 3'd1, 3'd1, 7'b1010000};
        tbl[5]  = '{4'h1, 4'h1, 4'h9, 4'hF, 4'hF, 4'hF, 1'b0, 3'd1, 3'd1, 7'b1010000};
        tbl[6]  = '{4'h1, 4'h7, 4'h1, 4'hF, 4'hF, 4'hF, 1'b0, 3'd1, 3'd1, 7'b0011000};
        tbl[7]  = '{4'h1, 4'h7, 4'h1, 4'hF, 4'hF, 4'hF, 1'b1, 3'd1, 3'd1, 7'b0000000};
        tbl[8]  = '{4'h9, 4'h7, 4'h1, 4'hF, 4'hF, 4'hF, 1'b0, 3'd1, 3'd1, 7'b1011000};
        tbl[9]  = '{4'h9, 4'h5, 4'h1, 4'h2, 4'hF, 4'h2, 1'b0, 3'd1, 3'd1, 7'b1101000};
        tbl[10] = '{4'h1, 4'h6, 4'h1, 4'hF, 4'hF, 4'hF, 1'b0, 3'd1, 3'd1, 7'b0000001};
        tbl[11] = '{4'h1, 4'h6, 4'h1, 4'hF, 4'hF, 4'hF, 1'b0, 3'd3, 3'd1, 7'b0000100};
        tbl[12] = '{4'h1, 4'h6, 4'h1, 4'hF, 4'hF, 4'hF, 1'b0, 3'd1, 3'd4, 7'b0000110};
        tbl[13] = '{4'h1, 4'h1, 4'h1, 4'hF, 4'hF, 4'hF, 1'b0, 3'd2, 3'd1, 7'b0000100};
        tbl[14] = '{4'h1, 4'h1, 4'h1, 4'hF, 4'hF, 4'hF, 1'b0, 3'd0, 3'd5, 7'b0000000};
        tbl[15] = '{4'h1, 4'h6, 4'h1, 4'h3, 4'hF, 4'h3, 1'b0, 3'd1, 3'd1, 7'b0000001};
        tbl[16] = '{4'h1, 4'h9, 4'h1, 4'hF, 4'hF, 4'hF, 1'b0, 3'd1, 3'd1, 7'b1010000};

        m_halted = 1'b0; m_final = 3'd1; m_cyc = 0; m_ret = 0; m_bub = 0;
        idle();
        rst_n = 1'b0;
        @(posedge clk); #1;
        tick(); tick();
        chk_regs("reset");
        rst_n = 1'b1;
        #1;
        for (int i = 0; i < 10; i++) begin
            chk_comb("idle");
            tick();
        end
        chk("idle.cycle", cycle_cnt, 64'd10);
        chk("idle.retire", retire_cnt, 64'd0);
        chk("idle.bubble", bubble_cnt, 64'd0);
        chk("idle.halted", 64'(halted), 64'd0);
        chk("idle.final", 64'(final_stat), 64'd1);

        // Single-cycle hazard vectors
        for (int i = 0; i < 17; i++) begin
            apply(tbl[i]);
            #1;
            chk($sformatf("vec%0d", i), 64'(dut_comb()), 64'(tbl[i].exp));
            idle();
            tick();
        end
        chk_regs("after_vec");

        // RET walks D -> E -> M
        base_bub = bubble_cnt;
        for (int s = 0; s < 3; s++) begin
            idle();
            if (s == 0) D_icode = 4'h9;
            if (s == 1) E_icode = 4'h9;
            if (s == 2) M_icode = 4'h9;
            #1;
            chk($sformatf("ret%0d.F_stall", s), 64'(F_stall), 64'd1);
            chk($sformatf("ret%0d.D_bubble", s), 64'(D_bubble), 64'd1);
            tick();
        end
        idle();
        chk("ret.bubble", bubble_cnt, base_bub + 64'd3);

        // Mispredict taken/not-taken
        base_bub = bubble_cnt;
        E_icode = 4'h7; e_Cnd = 1'b0;
        #1;
        chk("mis.D_bubble", 64'(D_bubble), 64'd1);
        chk("mis.E_bubble", 64'(E_bubble), 64'd1);
        tick();
        chk("mis.bubble", bubble_cnt, base_bub + 64'd2);
        e_Cnd = 1'b1;
        #1;
        chk("mis_ok.bubbles", 64'({D_bubble, E_bubble}), 64'd0);
        tick();
        chk("mis_ok.bubble", bubble_cnt, base_bub + 64'd2);

        // Exception drain into HALTED
        idle();
        E_icode = 4'h6; m_stat = 3'd3;
        #1;
        chk("drain1.M_bubble", 64'(M_bubble), 64'd1);
        chk("drain1.set_cc", 64'(set_cc), 64'd0);
        tick();
        m_stat = 3'd1; W_stat = 3'd3;
        #1;
        chk("drain2.M_bubble", 64'(M_bubble), 64'd1);
        chk("drain2.set_cc", 64'(set_cc), 64'd0);
        chk("drain2.W_stall", 64'(W_stall), 64'd1);
        chk("drain2.halted", 64'(halted), 64'd0);
        tick();
        chk("halt.halted", 64'(halted), 64'd1);
        chk("halt.final", 64'(final_stat), 64'd3);
        base_cyc = cycle_cnt; base_ret = retire_cnt; base_bub = bubble_cnt;
        idle();
        E_icode = 4'h7; D_icode = 4'h9; W_icode = 4'h6;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("halt.outs", 64'(dut_comb()), 64'b1100010);
            tick();
        end
        chk("halt.cycle", cycle_cnt, base_cyc);
        chk("halt.retire", retire_cnt, base_ret);
        chk("halt.bubble", bubble_cnt, base_bub);
        chk_regs("halt");
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        idle();
        chk("rst.halted", 64'(halted), 64'd0);
        chk("rst.cycle", cycle_cnt, 64'd0);
        chk("rst.retire", retire_cnt, 64'd0);
        chk("rst.bubble", bubble_cnt, 64'd0);

        // Retire counting: OPQ, NOP, OPQ, OPQ, NOP, OPQ
        for (int i = 0; i < 6; i++) begin
            W_icode = (i == 1 || i == 4) ? 4'h1 : 4'h6;
            tick();
        end
        idle();
        chk("retire.retire", retire_cnt, 64'd4);
        chk("retire.cycle", cycle_cnt, 64'd6);

        // Randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            logic [3:0] ic[7];
            ic = '{4'h0, 4'h1, 4'h5, 4'h6, 4'h7, 4'h9, 4'hB};
            D_icode = ic[$urandom_range(0, 6)];
            E_icode = ic[$urandom_range(0, 6)];
            M_icode = ic[$urandom_range(0, 6)];
            W_icode = ic[$urandom_range(0, 6)];
            d_srcA  = 4'($urandom_range(0, 15));
            d_srcB  = 4'($urandom_range(0, 15));
            E_dstM  = ($urandom_range(0, 3) == 0) ? d_srcA : 4'($urandom_range(0, 15));
            e_Cnd   = 1'($urandom_range(0, 1));
            m_stat  = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'd1;
            W_stat  = ($urandom_range(0, 39) == 0) ? 3'($urandom_range(2, 4)) :
                      (($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7)) & 3'b001 : 3'd1);
            rst_n   = m_halted ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 49) != 0);
            #1;
            chk_comb("rand.comb");
            tick();
            chk_regs("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
